// File: rtl/button_event_ctrl.sv
// Multi-channel push-button controller: 2-FF synchronizers, one shared 10 ms tick prescaler
// and per-channel debounce/event FSMs producing a debounced level and single-cycle strobes.
module button_event_ctrl #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned N            = 4,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_evt,
  output logic [N-1:0] release_evt,
  output logic [N-1:0] long_evt,
  output logic [N-1:0] repeat_evt
);

  localparam int unsigned TICK_DIV = CLK_FREQ / 100;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CMAX_LR  = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned CMAX     = (CMAX_LR > 2) ? CMAX_LR : 2;
  localparam int unsigned CW       = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StHeld,
    StLongHeld,
    StDbRelease
  } state_e;

  logic [PW-1:0] presc;
  logic          tick;
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_e        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          pressed_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
    logic          repeat_r;

    assign cnt_inc = cnt + 1'b1;

    // A sync change always takes priority over a tick arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= StIdle;
        cnt       <= '0;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;
        unique case (state)
          StIdle: begin
            if (sync2[i]) begin
              state <= StDbPress;
              cnt   <= '0;
            end
          end
          StDbPress: begin
            if (!sync2[i]) begin
              state <= StIdle;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == CW'(2)) begin
                state     <= StHeld;
                cnt       <= '0;
                press_r   <= 1'b1;
                pressed_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          StHeld: begin
            if (!sync2[i]) begin
              state <= StDbRelease;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == CW'(LONG_TICKS)) begin
                state  <= StLongHeld;
                cnt    <= '0;
                long_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          StLongHeld: begin
            if (!sync2[i]) begin
              state <= StDbRelease;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == CW'(REPEAT_TICKS)) begin
                cnt      <= '0;
                repeat_r <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          StDbRelease: begin
            // Returning high here is a release glitch: resume holding, long timing restarts.
            if (sync2[i]) begin
              state <= StHeld;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt_inc == CW'(2)) begin
                state     <= StIdle;
                cnt       <= '0;
                release_r <= 1'b1;
                pressed_r <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state <= StIdle;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign pressed[i]     = pressed_r;
    assign press_evt[i]   = press_r;
    assign release_evt[i] = release_r;
    assign long_evt[i]    = long_r;
    assign repeat_evt[i]  = repeat_r;
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: scenario tasks plus randomized stimulus, all
// compared cycle by cycle against a tick-counting behavioural model of the button rules.
module tb_button_event_ctrl;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned N        = 2;
  localparam int          LONG     = 5;
  localparam int          REPEAT   = 2;
  localparam int          TICK_DIV = CLK_FREQ / 100;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] pressed;
  logic [N-1:0] press_evt;
  logic [N-1:0] release_evt;
  logic [N-1:0] long_evt;
  logic [N-1:0] repeat_evt;

  int checks;
  int errors;
  int cyc;

  button_event_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .N           (N),
    .LONG_TICKS  (LONG),
    .REPEAT_TICKS(REPEAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .pressed    (pressed),
    .press_evt  (press_evt),
    .release_evt(release_evt),
    .long_evt   (long_evt),
    .repeat_evt (repeat_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: debounced level per channel, ticks seen during a disagreement, ticks held high.
  int           lvl [N];
  int           dis [N];
  int           dt  [N];
  int           held[N];
  int           pc;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] m_pressed;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  logic [N-1:0] m_long;
  logic [N-1:0] m_repeat;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      lvl[c]  = 0;
      dis[c]  = 0;
      dt[c]   = 0;
      held[c] = 0;
    end
    pc        = 0;
    s1        = '0;
    s2        = '0;
    m_pressed = '0;
    m_press   = '0;
    m_release = '0;
    m_long    = '0;
    m_repeat  = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] b);
    logic tk;
    tk        = (pc == TICK_DIV - 1);
    m_press   = '0;
    m_release = '0;
    m_long    = '0;
    m_repeat  = '0;
    for (int c = 0; c < N; c++) begin
      if ((s2[c] ? 1 : 0) != lvl[c]) begin
        held[c] = 0;
        if (dis[c] == 0) begin
          dis[c] = 1;
          dt[c]  = 0;
        end else if (tk) begin
          dt[c]++;
          if (dt[c] == 2) begin
            lvl[c] = 1 - lvl[c];
            if (lvl[c] == 1) m_press[c] = 1'b1;
            else m_release[c] = 1'b1;
            dis[c] = 0;
            dt[c]  = 0;
          end
        end
      end else if (dis[c] != 0) begin
        dis[c]  = 0;
        dt[c]   = 0;
        held[c] = 0;
      end else if (lvl[c] == 1 && tk) begin
        held[c]++;
        if (held[c] == LONG) m_long[c] = 1'b1;
        else if (held[c] > LONG && (held[c] - LONG) % REPEAT == 0) m_repeat[c] = 1'b1;
      end
      m_pressed[c] = (lvl[c] == 1);
    end
    s2 = s1;
    s1 = b;
    pc = (pc + 1) % TICK_DIV;
  endfunction

  function automatic logic [5*N-1:0] dut_vec();
    return {pressed, press_evt, release_evt, long_evt, repeat_evt};
  endfunction

  function automatic logic [5*N-1:0] exp_vec();
    return {m_pressed, m_press, m_release, m_long, m_repeat};
  endfunction

  task automatic step(input logic [N-1:0] b);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int first_hi;
    reset  = 1'b1;
    btn_in = '0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec(), {5 * N{1'b0}});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(2'b11);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_pre cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pressed !== 2'b11) begin
      errors++;
      $display("FAIL reset_pre_pressed got=%b exp=11", pressed);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", dut_vec(), {5 * N{1'b0}});
    end
    model_reset();
    @(negedge clk);
    reset    = 1'b0;
    first_hi = -1;
    for (int k = 1; k <= 40; k++) begin
      step(2'b11);
      if (pressed != '0 && first_hi < 0) first_hi = k;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_post cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (first_hi < 2 * TICK_DIV) begin
      errors++;
      $display("FAIL reset_hold first_pressed_edge=%0d required>=%0d", first_hi, 2 * TICK_DIV);
    end
    for (int k = 0; k < 40; k++) begin
      step(2'b00);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clean();
    int rise, fall, t_press, t_rel, n_press, n_rel, n_ch1;
    n_press = 0;
    n_rel   = 0;
    n_ch1   = 0;
    t_press = 0;
    t_rel   = 0;
    rise    = cyc + 1;
    for (int k = 0; k < 100; k++) begin
      step(2'b01);
      if (press_evt[0]) begin
        n_press++;
        t_press = cyc;
      end
      if (release_evt[0]) n_rel++;
      if (|{pressed[1], press_evt[1], release_evt[1], long_evt[1], repeat_evt[1]}) n_ch1++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_press != 1 || n_rel != 0) begin
      errors++;
      $display("FAIL clean_press_count press=%0d release=%0d required 1/0", n_press, n_rel);
    end
    checks++;
    if (t_press - rise < 11 || t_press - rise > 22) begin
      errors++;
      $display("FAIL clean_press_latency got=%0d required 11..22", t_press - rise);
    end
    checks++;
    if (pressed[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_pressed_hi got=%b exp=1", pressed[0]);
    end
    fall = cyc + 1;
    for (int k = 0; k < 60; k++) begin
      step(2'b00);
      if (release_evt[0]) begin
        n_rel++;
        t_rel = cyc;
      end
      if (press_evt[0]) n_press++;
      if (|{pressed[1], press_evt[1], release_evt[1], long_evt[1], repeat_evt[1]}) n_ch1++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clean_release cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_rel != 1 || n_press != 1) begin
      errors++;
      $display("FAIL clean_release_count release=%0d press=%0d required 1/1", n_rel, n_press);
    end
    checks++;
    if (t_rel - fall < 11 || t_rel - fall > 22) begin
      errors++;
      $display("FAIL clean_release_latency got=%0d required 11..22", t_rel - fall);
    end
    checks++;
    if (pressed[0] !== 1'b0 || n_ch1 != 0) begin
      errors++;
      $display("FAIL clean_end pressed0=%b ch1_activity=%0d required 0/0", pressed[0], n_ch1);
    end
  endtask

  task automatic test_bounce();
    int n_act;
    logic b;
    n_act = 0;
    b     = 1'b0;
    for (int k = 0; k < 240; k++) begin
      if (k < 200 && k % 7 == 0) b = ~b;
      if (k >= 200) b = 1'b0;
      step({1'b0, b});
      if (|{pressed, press_evt, release_evt, long_evt, repeat_evt}) n_act++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_act != 0) begin
      errors++;
      $display("FAIL bounce_quiet active_cycles=%0d required 0", n_act);
    end
  endtask

  task automatic test_long();
    int t_press, t_long, t_prev, n_press, n_long, n_rep, n_rel, bad_gap;
    n_press = 0;
    n_long  = 0;
    n_rep   = 0;
    n_rel   = 0;
    bad_gap = 0;
    t_press = 0;
    t_long  = 0;
    t_prev  = 0;
    for (int k = 0; k < 190; k++) begin
      step(k < 150 ? 2'b01 : 2'b00);
      if (press_evt[0]) begin
        n_press++;
        t_press = cyc;
      end
      if (long_evt[0]) begin
        n_long++;
        t_long = cyc;
        t_prev = cyc;
      end
      if (repeat_evt[0]) begin
        n_rep++;
        if (cyc - t_prev != REPEAT * TICK_DIV) bad_gap++;
        t_prev = cyc;
      end
      if (release_evt[0]) n_rel++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL long cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_press != 1 || n_long != 1 || n_rel != 1) begin
      errors++;
      $display("FAIL long_counts press=%0d long=%0d release=%0d required 1/1/1",
               n_press, n_long, n_rel);
    end
    checks++;
    if (t_long - t_press != LONG * TICK_DIV) begin
      errors++;
      $display("FAIL long_delay got=%0d required %0d", t_long - t_press, LONG * TICK_DIV);
    end
    checks++;
    if (n_rep < 3 || bad_gap != 0) begin
      errors++;
      $display("FAIL long_repeat count=%0d bad_gaps=%0d required >=3/0", n_rep, bad_gap);
    end
  endtask

  task automatic test_glitch();
    int g_end, t_long, n_press, n_rel, n_long;
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
    t_long  = 0;
    g_end   = 0;
    for (int k = 0; k < 138; k++) begin
      if (k >= 30 && k < 38) step(2'b00);
      else step(2'b01);
      if (k == 38) g_end = cyc;
      if (press_evt[0]) n_press++;
      if (release_evt[0]) n_rel++;
      if (long_evt[0]) begin
        n_long++;
        t_long = cyc;
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_press != 1 || n_rel != 0 || n_long != 1) begin
      errors++;
      $display("FAIL glitch_counts press=%0d release=%0d long=%0d required 1/0/1",
               n_press, n_rel, n_long);
    end
    checks++;
    if (t_long - g_end < 42 || t_long - g_end > 52) begin
      errors++;
      $display("FAIL glitch_long_restart got=%0d required 42..52", t_long - g_end);
    end
    for (int k = 0; k < 40; k++) begin
      step(2'b00);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_release cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_concurrent();
    int n_both, n_single, t_r0, t_r1, n_r0, n_r1;
    n_both   = 0;
    n_single = 0;
    n_r0     = 0;
    n_r1     = 0;
    t_r0     = 0;
    t_r1     = 0;
    for (int k = 0; k < 160; k++) begin
      if (k < 60) step(2'b11);
      else if (k < 90) step(2'b10);
      else step(2'b00);
      if (press_evt == 2'b11) n_both++;
      if (press_evt == 2'b01 || press_evt == 2'b10) n_single++;
      if (release_evt[0]) begin
        n_r0++;
        t_r0 = cyc;
      end
      if (release_evt[1]) begin
        n_r1++;
        t_r1 = cyc;
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL concurrent cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n_both != 1 || n_single != 0) begin
      errors++;
      $display("FAIL concurrent_press both=%0d single=%0d required 1/0", n_both, n_single);
    end
    checks++;
    if (n_r0 != 1 || n_r1 != 1 || t_r1 - t_r0 != 30) begin
      errors++;
      $display("FAIL concurrent_release r0=%0d r1=%0d gap=%0d required 1/1/30",
               n_r0, n_r1, t_r1 - t_r0);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] b;
    int len;
    for (int seg = 0; seg < 60; seg++) begin
      b   = N'($urandom_range(0, 3));
      len = $urandom_range(1, 70);
      for (int k = 0; k < len; k++) begin
        step(b);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_clean();
    test_bounce();
    test_long();
    test_glitch();
    test_concurrent();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
